// File: rtl/div_unit.sv
// rtl/div_unit.sv - multicycle signed restoring divider, one quotient bit per cycle
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             sign;
  logic             div0;
  logic             ovf;

  logic [WIDTH-1:0] abs_a_in;
  logic [WIDTH-1:0] abs_b_in;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   divisor_ext;
  logic             fits;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // Magnitudes of the incoming operands; MIN maps onto 2^(WIDTH-1) as an unsigned value.
  always_comb begin
    abs_a_in = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    abs_b_in = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  end

  // The shifted partial remainder carries one extra bit so a 2^(WIDTH-1) divisor compares exactly.
  always_comb begin
    rem_shift   = {rem, quo[WIDTH-1]};
    divisor_ext = {1'b0, abs_b};
    fits        = (rem_shift >= divisor_ext);
    rem_next    = fits ? WIDTH'(rem_shift - divisor_ext) : rem_shift[WIDTH-1:0];
    quo_next    = {quo[WIDTH-2:0], fits};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      abs_b          <= '0;
      rem            <= '0;
      quo            <= '0;
      sign           <= 1'b0;
      div0           <= 1'b0;
      ovf            <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_DIV) begin
        // A start in any state abandons whatever was in flight.
        state <= RUN;
        count <= '0;
        rem   <= '0;
        quo   <= abs_a_in;
        abs_b <= abs_b_in;
        sign  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        div0  <= (data_operandB == '0);
        ovf   <= (data_operandA == MIN_VAL) && (data_operandB == '1);
      end else begin
        case (state)
          RUN: begin
            rem   <= rem_next;
            quo   <= quo_next;
            count <= count + 1'b1;
            if (count == CW'(WIDTH - 1)) begin
              state <= DONE;
            end
          end
          DONE: begin
            state          <= IDLE;
            data_resultRDY <= 1'b1;
            if (div0) begin
              data_result    <= '0;
              data_exception <= 1'b1;
            end else if (ovf) begin
              data_result    <= MIN_VAL;
              data_exception <= 1'b1;
            end else begin
              data_result    <= sign ? -quo : quo;
              data_exception <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;

  localparam int WIDTH = 32;

  logic             clock;
  logic             reset;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  int total;
  int bad;

  div_unit #(.WIDTH(WIDTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one start pulse; returns once the capture edge has passed.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_DIV      = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'h0000_0001;
  endtask

  task automatic run_div(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] exp_q, input logic exp_exc);
    int n;
    start_op(a, b);
    n = 0;
    while (!data_resultRDY && n < 100) begin
      @(posedge clock);
      n++;
      @(negedge clock);
    end
    check({tag, " latency"}, 64'(n), 64'd33);
    check({tag, " result"}, 64'(data_result), 64'(exp_q));
    check({tag, " exc"}, 64'(data_exception), 64'(exp_exc));
    @(negedge clock);
    check({tag, " rdy pulse width"}, 64'(data_resultRDY), 64'd0);
    repeat (3) @(negedge clock);
    check({tag, " hold"}, 64'(data_result), 64'(exp_q));
  endtask

  initial begin
    int rdy_seen;
    total         = 0;
    bad           = 0;
    reset         = 1'b1;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(negedge clock);
    check("reset result", 64'(data_result), 64'd0);
    check("reset exc", 64'(data_exception), 64'd0);
    check("reset rdy", 64'(data_resultRDY), 64'd0);
    reset = 1'b0;

    run_div("100/7",   32'd100,        32'd7,          32'd14,         1'b0);
    run_div("-7/2",    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0);
    run_div("7/-2",    32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0);
    run_div("-8/-2",   32'hFFFF_FFF8,  32'hFFFF_FFFE,  32'd4,          1'b0);
    run_div("5/0",     32'd5,          32'd0,          32'd0,          1'b1);
    run_div("0/9",     32'd0,          32'd9,          32'd0,          1'b0);
    run_div("min/-1",  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1);
    run_div("min/min", 32'h8000_0000,  32'h8000_0000,  32'd1,          1'b0);
    run_div("-1000/33", 32'hFFFF_FC18, 32'd33,         32'hFFFF_FFE2,  1'b0);

    // Abort: restart with 9/3 ten cycles into 100/7; only the second op reports.
    start_op(32'd100, 32'd7);
    rdy_seen = 0;
    repeat (9) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
    end
    check("abort no early rdy", 64'(rdy_seen), 64'd0);
    run_div("abort 9/3", 32'd9, 32'd3, 32'd3, 1'b0);

    // Reset mid-operation.
    start_op(32'd100, 32'd7);
    repeat (14) @(negedge clock);
    check("pre-reset hold", 64'(data_result), 64'd3);
    reset = 1'b1;
    #1;
    check("mid reset result", 64'(data_result), 64'd0);
    check("mid reset exc", 64'(data_exception), 64'd0);
    check("mid reset rdy", 64'(data_resultRDY), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    rdy_seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
    end
    check("no rdy after reset", 64'(rdy_seen), 64'd0);
    run_div("post-reset 6/3", 32'd6, 32'd3, 32'd2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
